// File: rtl/aes_key_pkg.sv
// aes_key_pkg: shared constants, state encoding and helpers for the AES-256
// key sequencer (key256_sched) and its round-key store (rk_store).
package aes_key_pkg;

  localparam int NRK         = 15;   // round keys for AES-256
  localparam int RK_W        = 128;  // round-key width
  localparam int CK256_W     = 256;  // cipher-key width
  localparam int IDX_W       = 4;    // round-key index width
  localparam int TMO_W       = 6;    // expansion timeout counter width
  localparam int TIMEOUT_DEF = 40;   // default expansion budget in cycles

  // One-hot sequencer states
  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_EXPAND = 5'b00100,
    ST_READY  = 5'b01000,
    ST_FAULT  = 5'b10000
  } sched_state_e;

  // True when a round-key index addresses a real store entry
  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx,
                                        input logic [IDX_W-1:0] nrk);
    return (idx < nrk);
  endfunction

endpackage

// File: rtl/key256_sched_rk_store.sv
// rk_store: NRK x W round-key register file with per-entry valid bits.
// Ports:
//   clk, rst_n      clock, async active-low reset (clears valid bits, rdata)
//   clr             synchronous clear of all valid bits
//   we/widx/wdata   synchronous write; out-of-range indices are dropped
//   re/ridx/rdata   registered read; out-of-range or invalid entry reads 0
//   last_valid      valid bit of entry NRK-1 (final round key captured)
module rk_store #(
  parameter int NRK = 15,
  parameter int W   = 128,
  parameter int IW  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [IW-1:0] ridx,
  output logic [W-1:0]  rdata,
  output logic          last_valid
);
  import aes_key_pkg::*;

  localparam logic [IW-1:0] NRK_IDX = IW'(NRK);

  logic [W-1:0]   mem_q [NRK];
  logic [NRK-1:0] valid_q;
  logic [W-1:0]   rdata_q;
  logic           wr_ok_s;
  logic           rd_hit_s;

  assign wr_ok_s  = we && idx_in_range(widx, NRK_IDX);
  assign rd_hit_s = idx_in_range(ridx, NRK_IDX) && valid_q[ridx];

  // Key data array; validity is tracked separately so data needs no reset
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[widx] <= wdata;
    end
  end

  // Per-entry valid bits: clear-all has priority over a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= {NRK{1'b0}};
    end else if (clr) begin
      valid_q <= {NRK{1'b0}};
    end else if (wr_ok_s) begin
      valid_q[widx] <= 1'b1;
    end
  end

  // Registered read port; anything not backed by a valid entry reads as 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= {W{1'b0}};
    end else if (re) begin
      rdata_q <= rd_hit_s ? mem_q[ridx] : {W{1'b0}};
    end
  end

  assign rdata      = rdata_q;
  assign last_valid = valid_q[NRK-1];

endmodule

// File: rtl/key256_sched.sv
// key256_sched: sequencer and round-key store for the key256_exp expander.
// Accepts a 256-bit key, pulses start256, captures the NRK round keys the
// expander emits, then serves indexed round-key reads over req/ack.
// Ports:
//   mclk, arst_n                      clock, async active-low reset
//   key_load, key_in                  new-key pulse and key
//   cipher_busy                       cipher holds current key set
//   rk_req, rk_idx                    round-key read request / index
//   ck256_master, start256            key and start pulse to expander
//   rk256, rk256_count, rk256_le      round-key stream from expander
//   busy256                           expander busy (informational)
//   rk_out, rk_ack, rk_err            read data / ack / bad-index flag
//   keys_ready, key_err               key set valid / sticky timeout
module key256_sched #(
  parameter int NRK     = aes_key_pkg::NRK,
  parameter int TIMEOUT = aes_key_pkg::TIMEOUT_DEF
) (
  input  logic                            mclk,
  input  logic                            arst_n,
  input  logic                            key_load,
  input  logic [aes_key_pkg::CK256_W-1:0] key_in,
  input  logic                            cipher_busy,
  input  logic                            rk_req,
  input  logic [aes_key_pkg::IDX_W-1:0]   rk_idx,
  output logic [aes_key_pkg::CK256_W-1:0] ck256_master,
  output logic                            start256,
  input  logic [aes_key_pkg::RK_W-1:0]    rk256,
  input  logic [aes_key_pkg::IDX_W-1:0]   rk256_count,
  input  logic                            rk256_le,
  input  logic                            busy256,
  output logic [aes_key_pkg::RK_W-1:0]    rk_out,
  output logic                            rk_ack,
  output logic                            rk_err,
  output logic                            keys_ready,
  output logic                            key_err
);
  import aes_key_pkg::*;

  localparam logic [IDX_W-1:0] NRK_IDX = IDX_W'(NRK);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}};
  localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);

  sched_state_e       state_q;
  logic [CK256_W-1:0] ck_q;
  logic [CK256_W-1:0] pend_q;
  logic               pend_v_q;
  logic [TMO_W-1:0]   tmo_q;
  logic               start_q;
  logic               ready_q;
  logic               kerr_q;
  logic               ack_q;
  logic               err_q;

  logic               rd_accept_s;
  logic               st_we_s;
  logic               st_clr_s;
  logic               last_valid_s;
  logic               unused_busy_s;

  // The expander's busy flag carries no information the sequencer needs
  assign unused_busy_s = busy256;

  // A read is sampled only in READY and never while its ack is on the bus,
  // which spaces back-to-back reads two cycles apart.
  assign rd_accept_s = (state_q == ST_READY) && rk_req && !ack_q;
  // Expander output is only trusted between START and the end of EXPAND.
  assign st_we_s     = (state_q == ST_EXPAND) && rk256_le;
  // Store is invalidated on every new expansion and on a fault.
  assign st_clr_s    = (state_q == ST_START) || (state_q == ST_FAULT);

  rk_store #(
    .NRK (NRK),
    .W   (RK_W),
    .IW  (IDX_W)
  ) u_store (
    .clk        (mclk),
    .rst_n      (arst_n),
    .clr        (st_clr_s),
    .we         (st_we_s),
    .widx       (rk256_count),
    .wdata      (rk256),
    .re         (rd_accept_s),
    .ridx       (rk_idx),
    .rdata      (rk_out),
    .last_valid (last_valid_s)
  );

  // Sequencer FSM with pending key, timeout counter and registered outputs
  always_ff @(posedge mclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= ST_IDLE;
      ck_q     <= {CK256_W{1'b0}};
      pend_q   <= {CK256_W{1'b0}};
      pend_v_q <= 1'b0;
      tmo_q    <= {TMO_W{1'b0}};
      start_q  <= 1'b0;
      ready_q  <= 1'b0;
      kerr_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      ack_q   <= rd_accept_s;
      err_q   <= rd_accept_s && !idx_in_range(rk_idx, NRK_IDX);
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b0;
          // Cipher has no valid key set here, so cipher_busy is ignored
          if (key_load) begin
            ck_q    <= key_in;
            kerr_q  <= 1'b0;
            start_q <= 1'b1;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          tmo_q   <= {TMO_W{1'b0}};
          state_q <= ST_EXPAND;
          if (key_load) begin
            pend_q   <= key_in;
            pend_v_q <= 1'b1;
          end
        end
        ST_EXPAND: begin
          if (key_load) begin
            pend_q   <= key_in;
            pend_v_q <= 1'b1;
          end
          // Final round key landed on the previous edge
          if (last_valid_s) begin
            ready_q <= 1'b1;
            state_q <= ST_READY;
          end else if (tmo_q >= TMO_LIM) begin
            kerr_q  <= 1'b1;
            state_q <= ST_FAULT;
          end else if (tmo_q != TMO_MAX) begin
            tmo_q <= tmo_q + TMO_ONE;
          end
        end
        ST_READY: begin
          // A fresh key beats a pending one and discards it
          if (key_load && !cipher_busy) begin
            ck_q     <= key_in;
            pend_v_q <= 1'b0;
            kerr_q   <= 1'b0;
            ready_q  <= 1'b0;
            start_q  <= 1'b1;
            state_q  <= ST_START;
          end else if (key_load) begin
            pend_q   <= key_in;
            pend_v_q <= 1'b1;
          end else if (pend_v_q && !cipher_busy) begin
            ck_q     <= pend_q;
            pend_v_q <= 1'b0;
            kerr_q   <= 1'b0;
            ready_q  <= 1'b0;
            start_q  <= 1'b1;
            state_q  <= ST_START;
          end
        end
        ST_FAULT: begin
          // Key that was waiting on the failed expansion is abandoned
          pend_v_q <= 1'b0;
          ready_q  <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          pend_v_q <= 1'b0;
          ready_q  <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign ck256_master = ck_q;
  assign start256     = start_q;
  assign rk_ack       = ack_q;
  assign rk_err       = err_q;
  assign keys_ready   = ready_q;
  assign key_err      = kerr_q;

endmodule

// File: tb/tb_key256_sched.sv
module tb_key256_sched;

  localparam int NRK_T = 15;
  localparam int TMO_T = 40;
  localparam logic [255:0] FIPS_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

  logic         mclk = 1'b0;
  logic         arst_n = 1'b0;
  logic         key_load = 1'b0;
  logic [255:0] key_in = '0;
  logic         cipher_busy = 1'b0;
  logic         rk_req = 1'b0;
  logic [3:0]   rk_idx = '0;
  logic [255:0] ck256_master;
  logic         start256;
  logic [127:0] rk256 = '0;
  logic [3:0]   rk256_count = '0;
  logic         rk256_le = 1'b0;
  logic         busy256 = 1'b0;
  logic [127:0] rk_out;
  logic         rk_ack;
  logic         rk_err;
  logic         keys_ready;
  logic         key_err;

  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0;
  logic [127:0] rk_model [16];

  key256_sched #(.NRK(NRK_T), .TIMEOUT(TMO_T)) dut (
    .mclk(mclk), .arst_n(arst_n), .key_load(key_load), .key_in(key_in),
    .cipher_busy(cipher_busy), .rk_req(rk_req), .rk_idx(rk_idx),
    .ck256_master(ck256_master), .start256(start256), .rk256(rk256),
    .rk256_count(rk256_count), .rk256_le(rk256_le), .busy256(busy256),
    .rk_out(rk_out), .rk_ack(rk_ack), .rk_err(rk_err),
    .keys_ready(keys_ready), .key_err(key_err)
  );

  always #5 mclk = ~mclk;

  always @(negedge mclk) if (start256 === 1'b1) start_cnt++;

  task automatic tick();
    @(negedge mclk);
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic pulse_key(input logic [255:0] k);
    key_in = k; key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  // Bus model of key256_exp: one round key every 2 cycles; model records what it sent
  task automatic expand(input int first, input int last, input bit fips_last);
    for (int i = first; i <= last; i++) begin
      rk_model[i] = (fips_last && i == 14) ? FIPS_RK14 : rand128();
      rk256 = rk_model[i]; rk256_count = 4'(i); rk256_le = 1'b1;
      busy256 = 1'b1;
      tick();
      rk256_le = 1'b0;
      if (i != last) tick();
    end
    busy256 = 1'b0;
  endtask

  // Issue one read and report what came back (bounded wait)
  task automatic do_read(input logic [3:0] idx, output int lat, output logic [127:0] data,
                         output logic err, output logic ack_next);
    lat = -1; data = '0; err = 1'b0;
    rk_idx = idx; rk_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (rk_ack) begin lat = c; data = rk_out; err = rk_err; break; end
    end
    rk_req = 1'b0;
    tick();
    ack_next = rk_ack;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    repeat (2) tick();
    n_tests++;
    if ({ck256_master, start256, rk_out, rk_ack, rk_err, keys_ready, key_err} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    arst_n = 1'b1;
    repeat (2) tick();
    n_tests++;
    if ({start256, keys_ready, key_err, rk_ack} !== 4'b0000) begin
      n_fail++; $display("FAIL idle_after_reset: got %b required 0000", {start256, keys_ready, key_err, rk_ack});
    end
  endtask

  task automatic test_expand_fips();
    int s0;
    pulse_key(FIPS_KEY);
    n_tests++;
    if (start256 !== 1'b1) begin n_fail++; $display("FAIL start_latency: got %b required 1", start256); end
    n_tests++;
    if (ck256_master !== FIPS_KEY) begin n_fail++; $display("FAIL ck256_master: got %h required %h", ck256_master, FIPS_KEY); end
    s0 = start_cnt;
    tick();
    n_tests++;
    if (start256 !== 1'b0) begin n_fail++; $display("FAIL start_one_pulse: got %b required 0", start256); end
    expand(0, 14, 1'b1);
    n_tests++;
    if (keys_ready !== 1'b0) begin n_fail++; $display("FAIL ready_early: got %b required 0", keys_ready); end
    tick();
    n_tests++;
    if (keys_ready !== 1'b1) begin n_fail++; $display("FAIL ready_rise: got %b required 1", keys_ready); end
    n_tests++;
    if (start_cnt != s0 + 1) begin n_fail++; $display("FAIL start_count: got %0d required 1", start_cnt - s0); end
  endtask

  task automatic test_reads();
    int lat; logic [127:0] d; logic e, an; logic [3:0] idx;
    do_read(4'd14, lat, d, e, an);
    n_tests++;
    if (lat != 1 || d !== FIPS_RK14 || e !== 1'b0 || an !== 1'b0) begin
      n_fail++; $display("FAIL read_idx14: got lat=%0d data=%h err=%b ack_next=%b required lat=1 data=%h err=0 ack_next=0", lat, d, e, an, FIPS_RK14);
    end
    for (int k = 0; k < 4; k++) begin
      idx = 4'($urandom_range(13, 0));
      do_read(idx, lat, d, e, an);
      n_tests++;
      if (lat != 1 || d !== rk_model[idx] || e !== 1'b0) begin
        n_fail++; $display("FAIL read_rand idx=%0d: got lat=%0d data=%h err=%b required lat=1 data=%h err=0", idx, lat, d, e, rk_model[idx]);
      end
    end
    do_read(4'd15, lat, d, e, an);
    n_tests++;
    if (lat != 1 || d !== 128'd0 || e !== 1'b1) begin
      n_fail++; $display("FAIL read_bad_idx: got lat=%0d data=%h err=%b required lat=1 data=0 err=1", lat, d, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] pat; logic [3:0] idx; bit data_ok;
    idx = 4'($urandom_range(13, 0));
    data_ok = 1'b1; pat = '0;
    rk_idx = idx; rk_req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      pat[c] = rk_ack;
      if (rk_ack && rk_out !== rk_model[idx]) data_ok = 1'b0;
    end
    rk_req = 1'b0;
    tick();
    n_tests++;
    if (pat !== 6'b010101) begin n_fail++; $display("FAIL b2b_ack_pattern: got %b required 010101", pat); end
    n_tests++;
    if (!data_ok) begin n_fail++; $display("FAIL b2b_data: got wrong rk_out, required %h", rk_model[idx]); end
  endtask

  task automatic test_pending();
    int s0, lat; logic [255:0] k2, k3;
    k2 = rand256(); k3 = rand256();
    s0 = start_cnt;
    cipher_busy = 1'b1;
    pulse_key(k2);
    repeat (2) tick();
    pulse_key(k3);
    repeat (6) tick();
    n_tests++;
    if (start_cnt != s0) begin n_fail++; $display("FAIL pending_no_start: got %0d starts required 0", start_cnt - s0); end
    n_tests++;
    if (keys_ready !== 1'b1) begin n_fail++; $display("FAIL pending_ready_held: got %b required 1", keys_ready); end
    s0 = start_cnt;
    cipher_busy = 1'b0;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (start256) begin lat = c; break; end
    end
    n_tests++;
    if (lat < 0 || ck256_master !== k3 || keys_ready !== 1'b0) begin
      n_fail++; $display("FAIL pending_consume: got lat=%0d ck=%h ready=%b required ck=%h ready=0", lat, ck256_master, keys_ready, k3);
    end
    tick();
    expand(0, 14, 1'b0);
    repeat (2) tick();
    n_tests++;
    if (start_cnt != s0 + 1 || keys_ready !== 1'b1) begin
      n_fail++; $display("FAIL pending_single_start: got starts=%0d ready=%b required starts=1 ready=1", start_cnt - s0, keys_ready);
    end
  endtask

  task automatic test_timeout();
    int lat; logic [255:0] k5;
    pulse_key(rand256());
    lat = -1;
    fork
      begin tick(); expand(0, 9, 1'b0); end
      begin
        for (int c = 1; c <= 80; c++) begin
          tick();
          if (key_err) begin lat = c; break; end
        end
      end
    join
    n_tests++;
    if (lat < TMO_T || lat > TMO_T + 3) begin
      n_fail++; $display("FAIL timeout_latency: got %0d cycles required %0d..%0d", lat, TMO_T, TMO_T + 3);
    end
    n_tests++;
    if (keys_ready !== 1'b0) begin n_fail++; $display("FAIL fault_not_ready: got %b required 0", keys_ready); end
    repeat (3) tick();
    n_tests++;
    if (key_err !== 1'b1 || keys_ready !== 1'b0 || start256 !== 1'b0) begin
      n_fail++; $display("FAIL fault_idle: got err=%b ready=%b start=%b required 1 0 0", key_err, keys_ready, start256);
    end
    k5 = rand256();
    pulse_key(k5);
    n_tests++;
    if (key_err !== 1'b0 || start256 !== 1'b1 || ck256_master !== k5) begin
      n_fail++; $display("FAIL key_err_clear: got err=%b start=%b required err=0 start=1", key_err, start256);
    end
  endtask

  // Entered with start256 visible for a fresh expansion
  task automatic test_req_during_expand();
    int acks; logic rdy_at_ack; logic [127:0] d; logic [3:0] idx;
    acks = 0; rdy_at_ack = 1'b0; d = '0;
    idx = 4'($urandom_range(13, 0));
    fork
      begin tick(); expand(0, 14, 1'b0); end
      begin
        rk_idx = idx; rk_req = 1'b1;
        for (int c = 1; c <= 60; c++) begin
          tick();
          if (rk_ack) begin
            acks++;
            if (acks == 1) begin rdy_at_ack = keys_ready; d = rk_out; end
            rk_req = 1'b0;
          end
        end
        rk_req = 1'b0;
      end
    join
    n_tests++;
    if (acks != 1 || rdy_at_ack !== 1'b1) begin
      n_fail++; $display("FAIL stalled_req_ack: got acks=%0d ready_at_ack=%b required acks=1 ready=1", acks, rdy_at_ack);
    end
    n_tests++;
    if (d !== rk_model[idx]) begin n_fail++; $display("FAIL stalled_req_data: got %h required %h", d, rk_model[idx]); end
  endtask

  task automatic test_reset_mid_expand();
    int s0, acks;
    pulse_key(rand256());
    tick();
    expand(0, 5, 1'b0);
    arst_n = 1'b0;
    #1;
    n_tests++;
    if ({ck256_master, start256, rk_out, rk_ack, rk_err, keys_ready, key_err} !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got nonzero outputs, required all 0");
    end
    tick();
    arst_n = 1'b1;
    s0 = start_cnt;
    tick();
    expand(6, 14, 1'b0);
    repeat (3) tick();
    n_tests++;
    if (keys_ready !== 1'b0 || start_cnt != s0) begin
      n_fail++; $display("FAIL late_pulses_ignored: got ready=%b starts=%0d required ready=0 starts=0", keys_ready, start_cnt - s0);
    end
    acks = 0;
    rk_idx = 4'd3; rk_req = 1'b1;
    repeat (5) begin tick(); if (rk_ack) acks++; end
    rk_req = 1'b0;
    n_tests++;
    if (acks != 0) begin n_fail++; $display("FAIL idle_read_stall: got %0d acks required 0", acks); end
  endtask

  initial begin
    test_reset();
    test_expand_fips();
    test_reads();
    test_back_to_back();
    test_pending();
    test_timeout();
    test_req_during_expand();
    test_reset_mid_expand();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key256_sched.md
# key256_sched

Sequencer and round-key store for the `key256_exp` expander. It accepts a 256-bit cipher key from the host and pulses `start256` on the expander. It captures the 15 round keys the expander emits into a local store, then serves indexed round-key reads to the cipher round engine over a req/ack handshake. A key change that arrives while the cipher holds the key set, or while an expansion is running, is deferred through a one-deep pending register.

## Interface
Parameters:
- NRK, 15, number of round keys stored (AES-256)
- TIMEOUT, 40, cycles allowed from `start256` to capture of round key NRK-1

Ports:
- mclk  in  1  master clock, all logic on rising edge
- arst_n  in  1  asynchronous active-low reset
- key_load  in  1  one-cycle pulse: new key on key_in
- key_in  in  256  cipher key [0:255], sampled when key_load=1
- cipher_busy  in  1  cipher engine holds the current key set; no key swap allowed
- rk_req  in  1  round-key read request, held until rk_ack
- rk_idx  in  4  requested round-key index, stable while rk_req=1
- ck256_master  out  256  registered key to expander
- start256  out  1  one-cycle start pulse to expander
- rk256  in  128  round key from expander
- rk256_count  in  4  index of rk256
- rk256_le  in  1  rk256 valid this cycle
- busy256  in  1  expander busy
- rk_out  out  128  round-key read data, valid with rk_ack
- rk_ack  out  1  one-cycle read acknowledge
- rk_err  out  1  with rk_ack: rk_idx >= NRK, rk_out=0
- keys_ready  out  1  full key set valid
- key_err  out  1  sticky: expansion timeout; cleared by next accepted key_load

## Operation
- States, one-hot 5 bits:
  - IDLE
  - START
  - EXPAND
  - READY
  - FAULT
- IDLE:
  - key_load → latch key_in into ck256_master, clear store valid bits → START.
  - key_load is accepted in IDLE even if cipher_busy=1.
- START: start256=1 for exactly one cycle, clear timeout counter → EXPAND.
- EXPAND:
  - Each cycle with rk256_le=1, write rk256 to store[rk256_count] and set valid[rk256_count].
  - The write of index NRK-1 → READY on the next edge.
  - Timeout counter reaching TIMEOUT → FAULT.
  - rk256_le with rk256_count >= NRK: write dropped.
- READY:
  - keys_ready=1.
  - key_load with cipher_busy=0 → latch key, drop keys_ready → START.
  - key_load with cipher_busy=1 → pending.
  - Pending with cipher_busy=0 → consume pending into ck256_master → START.
- FAULT: key_err=1, store invalid → IDLE next cycle. key_err remains set.
- Pending register:
  - One deep; a later key_load overwrites it (last wins).
  - key_load during START/EXPAND also goes to pending. It is consumed on entering READY when cipher_busy=0; otherwise it waits in READY.
  - key_load in the same cycle as a pending consume: the new key wins, and pending is cleared.
- Reads:
  - Served only in READY.
  - In other states rk_req stalls with no ack.
  - A request in flight when READY is left is not acked until READY returns.

## Timing
- Reset values, asserted asynchronously on arst_n low:
  - State IDLE.
  - All outputs 0.
  - ck256_master=0.
  - Valid bits clear, pending empty, key_err=0.
- key_load (IDLE) → start256 one cycle later; ck256_master stable from that cycle until the next START.
- Capture of index NRK-1 at edge N → keys_ready=1 after edge N+1.
- Read latency: rk_req sampled high in READY at edge N → rk_ack=1 and rk_out valid in cycle N+1.
  - rk_ack deasserts the following cycle, even if rk_req is still high.
  - A new request can be sampled at edge N+2, so back-to-back reads occur every 2 cycles.
- keys_ready falls in the same cycle START is entered.
- Timeout counter: 6-bit, saturating, counts cycles in EXPAND.
- Reset mid-expansion: immediate IDLE, store invalid, pending lost. Expander outputs are ignored until the next START.

## Structure
- Shared package `aes_key_pkg`:
  - State encodings (IDLE..FAULT).
  - NRK, RK_W=128, CK256_W=256.
  - Default TIMEOUT.
- Sub-module `rk_store`:
  - NRK×128 register file.
  - Synchronous write port (we, widx, wdata).
  - Registered read port (re, ridx, rdata).
  - Per-entry valid bits with a synchronous clear-all input.
- Top level holds:
  - The FSM.
  - The pending register.
  - The timeout counter.
  - The read handshake.

## Test plan
- Reset, then key_load with the FIPS-197 C.3 key 000102…1f (bus model of expander emitting 15 keys, 2 cycles apart) → start256 one pulse. keys_ready rises 1 cycle after index 14 is written. Read idx 14 returns the round key captured at index 14 (FIPS C.3 last round key 24fc79ccbf0979e9371ac23c6d68de36).
- rk_req idx 15 in READY → rk_ack with rk_err=1, rk_out=0.
- cipher_busy=1 in READY, then key_load(K2) then key_load(K3) → no start256. Drop cipher_busy → single start256 with ck256_master=K3.
- Expander model stops after index 9 → FAULT at TIMEOUT, key_err=1, then IDLE with keys_ready=0. Next key_load clears key_err.
- rk_req during EXPAND → no ack until READY, then ack exactly once.
- arst_n low for 1 cycle mid-EXPAND → all outputs 0. Late rk256_le pulses are not written, and keys_ready stays 0.
